// File: rtl/amt_recovery_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// amt_recovery_sequencer_pkg
// Shared types and constants for the AMT -> RMT recovery sequencer.
//   - rec_state_e : sequencer state encoding (IDLE, WALK, DRAIN, DONE)
//   - rmt_pkt_t   : one RMT write packet {logical index, physical tag}
//   - NUM_GROUPS  : number of LANES-wide groups needed to cover the map
//   - LAST_MASK   : lane-valid mask of the final (possibly partial) group
// ---------------------------------------------------------------------------
package amt_recovery_sequencer_pkg;

    localparam int DEF_NUM_LOG_REGS = 34;
    localparam int DEF_LOG_W        = 6;
    localparam int DEF_PHY_W        = 7;
    localparam int DEF_LANES        = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rec_state_e;

    typedef struct packed {
        logic [DEF_LOG_W-1:0] idx;
        logic [DEF_PHY_W-1:0] tag;
    } rmt_pkt_t;

    function automatic int calc_num_groups(input int num_regs, input int lanes);
        return (num_regs + lanes - 1) / lanes;
    endfunction

    // Lanes of the last group that still map onto real entries.
    function automatic logic [DEF_LANES-1:0] calc_last_mask(input int num_regs, input int lanes);
        logic [DEF_LANES-1:0] mask;
        int                   base;
        base = (calc_num_groups(num_regs, lanes) - 1) * lanes;
        for (int k = 0; k < DEF_LANES; k++) begin
            mask[k] = ((base + k) < num_regs) && (k < lanes);
        end
        return mask;
    endfunction

    localparam int                   NUM_GROUPS = calc_num_groups(DEF_NUM_LOG_REGS, DEF_LANES);
    localparam logic [DEF_LANES-1:0] LAST_MASK  = calc_last_mask(DEF_NUM_LOG_REGS, DEF_LANES);

endpackage

// File: rtl/amt_recovery_sequencer_if.sv
// ---------------------------------------------------------------------------
// amt_recovery_sequencer_if
// Bundles the ActiveList request, AMT read ports, RMT write ports and status
// of the recovery sequencer.
//   slave  modport : sequencer side
//   master modport : environment side (ActiveList / AMT / RMT)
// Optional macro RECOVER_STATS_EN adds recoverCount_o and stallCycles_o.
// ---------------------------------------------------------------------------
interface amt_recovery_sequencer_if #(
    parameter int LOG_W = 6,
    parameter int PHY_W = 7,
    parameter int LANES = 4
);
    logic                   recoverReq_i;
    logic                   commitStall_o;
    logic [LOG_W-1:0]       amtRdAddr0_o;
    logic [LOG_W-1:0]       amtRdAddr1_o;
    logic [LOG_W-1:0]       amtRdAddr2_o;
    logic [LOG_W-1:0]       amtRdAddr3_o;
    logic [PHY_W-1:0]       amtRdData0_i;
    logic [PHY_W-1:0]       amtRdData1_i;
    logic [PHY_W-1:0]       amtRdData2_i;
    logic [PHY_W-1:0]       amtRdData3_i;
    logic [LANES-1:0]       rmtWe_o;
    logic [LOG_W+PHY_W-1:0] rmtPacket0_o;
    logic [LOG_W+PHY_W-1:0] rmtPacket1_o;
    logic [LOG_W+PHY_W-1:0] rmtPacket2_o;
    logic [LOG_W+PHY_W-1:0] rmtPacket3_o;
    logic                   rmtReady_i;
    logic                   recoverBusy_o;
    logic                   recoverDone_o;
    logic                   overrunErr_o;
`ifdef RECOVER_STATS_EN
    logic [15:0]            recoverCount_o;
    logic [15:0]            stallCycles_o;
`endif

    modport slave (
        input  recoverReq_i, amtRdData0_i, amtRdData1_i, amtRdData2_i, amtRdData3_i, rmtReady_i,
        output commitStall_o, amtRdAddr0_o, amtRdAddr1_o, amtRdAddr2_o, amtRdAddr3_o,
               rmtWe_o, rmtPacket0_o, rmtPacket1_o, rmtPacket2_o, rmtPacket3_o,
               recoverBusy_o, recoverDone_o, overrunErr_o
`ifdef RECOVER_STATS_EN
        , output recoverCount_o, stallCycles_o
`endif
    );

    modport master (
        output recoverReq_i, amtRdData0_i, amtRdData1_i, amtRdData2_i, amtRdData3_i, rmtReady_i,
        input  commitStall_o, amtRdAddr0_o, amtRdAddr1_o, amtRdAddr2_o, amtRdAddr3_o,
               rmtWe_o, rmtPacket0_o, rmtPacket1_o, rmtPacket2_o, rmtPacket3_o,
               recoverBusy_o, recoverDone_o, overrunErr_o
`ifdef RECOVER_STATS_EN
        , input recoverCount_o, stallCycles_o
`endif
    );
endinterface

// File: rtl/amt_recover_outreg.sv
// ---------------------------------------------------------------------------
// amt_recover_outreg
// LANES-wide output register feeding the RMT write ports. Captures a packet
// group plus lane-valid mask on load, holds it while the RMT is not ready and
// empties it once accepted. The mask register doubles as the write enables.
//   clk, reset      : clock, async active-low reset
//   load            : capture in_mask / in_pkt this cycle
//   accept          : RMT ready; the held group is consumed
//   out_valid       : a group is held
//   out_mask        : per-lane write enables (zero when empty)
//   out_pkt         : held packets
// ---------------------------------------------------------------------------
module amt_recover_outreg #(
    parameter int LANES = 4,
    parameter int PKT_W = 13
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic                         accept,
    input  logic [LANES-1:0]             in_mask,
    input  logic [LANES-1:0][PKT_W-1:0]  in_pkt,
    output logic                         out_valid,
    output logic [LANES-1:0]             out_mask,
    output logic [LANES-1:0][PKT_W-1:0]  out_pkt
);
    logic                        valid_r;
    logic [LANES-1:0]            mask_r;
    logic [LANES-1:0][PKT_W-1:0] pkt_r;

    // Capture on load, drop the enables on acceptance, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= 1'b0;
            mask_r  <= {LANES{1'b0}};
            pkt_r   <= {(LANES*PKT_W){1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            mask_r  <= in_mask;
            pkt_r   <= in_pkt;
        end else if (accept && valid_r) begin
            valid_r <= 1'b0;
            mask_r  <= {LANES{1'b0}};
        end else begin
            valid_r <= valid_r;
            mask_r  <= mask_r;
        end
    end

    assign out_valid = valid_r;
    assign out_mask  = mask_r;
    assign out_pkt   = pkt_r;
endmodule

// File: rtl/amt_recovery_sequencer.sv
// ---------------------------------------------------------------------------
// amt_recovery_sequencer
// Restores the whole rename map from the architectural map after a flush:
// walks the AMT LANES entries per cycle and streams {index, tag} packets into
// the RMT write ports, honouring RMT backpressure, while stalling commit.
//   clk    : clock
//   reset  : asynchronous active-low reset (aborts a walk immediately)
//   bus    : amt_recovery_sequencer_if.slave (request, AMT reads, RMT
//            writes, busy/done/overrun status)
// Optional macro RECOVER_STATS_EN adds saturating restore / stall counters.
// ---------------------------------------------------------------------------
module amt_recovery_sequencer
    import amt_recovery_sequencer_pkg::*;
#(
    parameter int NUM_LOG_REGS = DEF_NUM_LOG_REGS,
    parameter int LOG_W        = DEF_LOG_W,
    parameter int PHY_W        = DEF_PHY_W,
    parameter int LANES        = DEF_LANES
) (
    input logic                     clk,
    input logic                     reset,
    amt_recovery_sequencer_if.slave bus
);
    localparam int             PKT_W      = LOG_W + PHY_W;
    // grpCnt carries one extra bit so grpCnt + LANES never wraps.
    localparam logic [LOG_W:0] NUM_REGS_W = (LOG_W+1)'(NUM_LOG_REGS);
    localparam logic [LOG_W:0] LANES_W    = (LOG_W+1)'(LANES);

    rec_state_e                  state_r;
    rec_state_e                  state_next_s;
    logic [LOG_W:0]              grp_cnt_r;
    logic                        load_s;
    logic                        last_grp_s;
    logic                        out_valid_s;
    logic [LANES-1:0][LOG_W:0]   idx_s;
    logic [LANES-1:0][LOG_W-1:0] rd_addr_s;
    logic [LANES-1:0][PHY_W-1:0] rd_data_s;
    logic [LANES-1:0][PKT_W-1:0] in_pkt_s;
    logic [LANES-1:0][PKT_W-1:0] out_pkt_s;
    logic [LANES-1:0]            in_mask_s;
    logic [LANES-1:0]            out_mask_s;
    logic                        busy_r;
    logic                        done_r;
    logic                        overrun_r;

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            assign idx_s[k]     = grp_cnt_r + (LOG_W+1)'(k);
            assign rd_addr_s[k] = (state_r == WALK) ? idx_s[k][LOG_W-1:0] : {LOG_W{1'b0}};
            assign in_mask_s[k] = (idx_s[k] < NUM_REGS_W);
            assign in_pkt_s[k]  = {idx_s[k][LOG_W-1:0], rd_data_s[k]};
        end
    endgenerate

    assign rd_data_s[0]     = bus.amtRdData0_i;
    assign rd_data_s[1]     = bus.amtRdData1_i;
    assign rd_data_s[2]     = bus.amtRdData2_i;
    assign rd_data_s[3]     = bus.amtRdData3_i;
    assign bus.amtRdAddr0_o = rd_addr_s[0];
    assign bus.amtRdAddr1_o = rd_addr_s[1];
    assign bus.amtRdAddr2_o = rd_addr_s[2];
    assign bus.amtRdAddr3_o = rd_addr_s[3];

    // A new group may enter whenever the register is empty or being drained.
    assign load_s     = (state_r == WALK) && (!out_valid_s || bus.rmtReady_i);
    assign last_grp_s = ((grp_cnt_r + LANES_W) >= NUM_REGS_W);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; requests outside IDLE never change the walk.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.recoverReq_i) state_next_s = WALK;
                else                  state_next_s = IDLE;
            end
            WALK: begin
                if (load_s && last_grp_s) state_next_s = DRAIN;
                else                      state_next_s = WALK;
            end
            DRAIN: begin
                if (bus.rmtReady_i) state_next_s = DONE;
                else                state_next_s = DRAIN;
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Group counter: cleared on a new restore, advanced on every load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grp_cnt_r <= {(LOG_W+1){1'b0}};
        end else if ((state_r == IDLE) && bus.recoverReq_i) begin
            grp_cnt_r <= {(LOG_W+1){1'b0}};
        end else if (load_s) begin
            grp_cnt_r <= grp_cnt_r + LANES_W;
        end else begin
            grp_cnt_r <= grp_cnt_r;
        end
    end

    // Registered status derived from the upcoming state; overrun is sticky.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            busy_r    <= (state_next_s != IDLE);
            done_r    <= (state_next_s == DONE);
            if (bus.recoverReq_i && (state_r != IDLE)) overrun_r <= 1'b1;
            else                                       overrun_r <= overrun_r;
        end
    end

    amt_recover_outreg #(
        .LANES (LANES),
        .PKT_W (PKT_W)
    ) u_outreg (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .accept    (bus.rmtReady_i),
        .in_mask   (in_mask_s),
        .in_pkt    (in_pkt_s),
        .out_valid (out_valid_s),
        .out_mask  (out_mask_s),
        .out_pkt   (out_pkt_s)
    );

    assign bus.rmtWe_o       = out_mask_s;
    assign bus.rmtPacket0_o  = out_pkt_s[0];
    assign bus.rmtPacket1_o  = out_pkt_s[1];
    assign bus.rmtPacket2_o  = out_pkt_s[2];
    assign bus.rmtPacket3_o  = out_pkt_s[3];
    assign bus.commitStall_o = busy_r;
    assign bus.recoverBusy_o = busy_r;
    assign bus.recoverDone_o = done_r;
    assign bus.overrunErr_o  = overrun_r;

`ifdef RECOVER_STATS_EN
    logic [15:0] recover_cnt_r;
    logic [15:0] stall_cnt_r;

    // Saturating counters of accepted restores and backpressured cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            recover_cnt_r <= 16'd0;
            stall_cnt_r   <= 16'd0;
        end else begin
            if ((state_r == IDLE) && bus.recoverReq_i && (recover_cnt_r != 16'hFFFF))
                recover_cnt_r <= recover_cnt_r + 16'd1;
            else
                recover_cnt_r <= recover_cnt_r;
            if (out_valid_s && !bus.rmtReady_i && (stall_cnt_r != 16'hFFFF))
                stall_cnt_r <= stall_cnt_r + 16'd1;
            else
                stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.recoverCount_o = recover_cnt_r;
    assign bus.stallCycles_o  = stall_cnt_r;
`endif
endmodule

// File: tb/tb_amt_recovery_sequencer.sv
// ---------------------------------------------------------------------------
// tb_amt_recovery_sequencer
// Scoreboard bench: every restore pushes its expected packet groups, which
// are popped as the RMT accepts them. Two DUTs: default size (34 entries) and
// an exact multiple of the lane count (32 entries). AMT entry i holds i+40.
// ---------------------------------------------------------------------------
module tb_amt_recovery_sequencer;
    import amt_recovery_sequencer_pkg::*;

    typedef struct packed {
        logic [7:0]         grp;
        logic [3:0]         mask;
        rmt_pkt_t [3:0]     pkts;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req = 1'b0;
    logic ready = 1'b1;
    logic sel = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    amt_recovery_sequencer_if #(.LOG_W(6), .PHY_W(7), .LANES(4)) bus_a ();
    amt_recovery_sequencer_if #(.LOG_W(6), .PHY_W(7), .LANES(4)) bus_b ();

    amt_recovery_sequencer #(.NUM_LOG_REGS(34), .LOG_W(6), .PHY_W(7), .LANES(4))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    amt_recovery_sequencer #(.NUM_LOG_REGS(32), .LOG_W(6), .PHY_W(7), .LANES(4))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    always #5 clk = ~clk;

    // Requests go to the selected DUT; ready is shared.
    assign bus_a.recoverReq_i = req & ~sel;
    assign bus_b.recoverReq_i = req & sel;
    assign bus_a.rmtReady_i   = ready;
    assign bus_b.rmtReady_i   = ready;

    // AMT model: entry i holds physical tag i+40.
    assign bus_a.amtRdData0_i = 7'(bus_a.amtRdAddr0_o) + 7'd40;
    assign bus_a.amtRdData1_i = 7'(bus_a.amtRdAddr1_o) + 7'd40;
    assign bus_a.amtRdData2_i = 7'(bus_a.amtRdAddr2_o) + 7'd40;
    assign bus_a.amtRdData3_i = 7'(bus_a.amtRdAddr3_o) + 7'd40;
    assign bus_b.amtRdData0_i = 7'(bus_b.amtRdAddr0_o) + 7'd40;
    assign bus_b.amtRdData1_i = 7'(bus_b.amtRdAddr1_o) + 7'd40;
    assign bus_b.amtRdData2_i = 7'(bus_b.amtRdAddr2_o) + 7'd40;
    assign bus_b.amtRdData3_i = 7'(bus_b.amtRdAddr3_o) + 7'd40;

    logic [3:0]       obs_we;
    logic [3:0][12:0] obs_pkts;
    logic [5:0]       obs_addr0;
    logic             obs_busy, obs_stall, obs_done, obs_ovr;

    always_comb begin
        if (sel) begin
            obs_we    = bus_b.rmtWe_o;
            obs_pkts  = {bus_b.rmtPacket3_o, bus_b.rmtPacket2_o, bus_b.rmtPacket1_o, bus_b.rmtPacket0_o};
            obs_addr0 = bus_b.amtRdAddr0_o;
            obs_busy  = bus_b.recoverBusy_o;
            obs_stall = bus_b.commitStall_o;
            obs_done  = bus_b.recoverDone_o;
            obs_ovr   = bus_b.overrunErr_o;
        end else begin
            obs_we    = bus_a.rmtWe_o;
            obs_pkts  = {bus_a.rmtPacket3_o, bus_a.rmtPacket2_o, bus_a.rmtPacket1_o, bus_a.rmtPacket0_o};
            obs_addr0 = bus_a.amtRdAddr0_o;
            obs_busy  = bus_a.recoverBusy_o;
            obs_stall = bus_a.commitStall_o;
            obs_done  = bus_a.recoverDone_o;
            obs_ovr   = bus_a.overrunErr_o;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_groups(input int n);
        exp_t e;
        int   idx;
        for (int g = 0; g < (n + 3) / 4; g++) begin
            e.grp = 8'(g);
            for (int k = 0; k < 4; k++) begin
                idx          = g * 4 + k;
                e.mask[k]    = (idx < n);
                e.pkts[k].idx = 6'(idx);
                e.pkts[k].tag = 7'(idx + 40);
            end
            sb.push_back(e);
        end
    endtask

    // One restore on the selected DUT. sa/sb_g: groups held off for slen
    // cycles; ovr_at: cycle of a second request; rst_grp: group at which
    // reset is asserted; req_at_done: request during the DONE cycle.
    task automatic run_restore(input int n, input int sa, input int sb_g, input int slen,
                               input int ovr_at, input int rst_grp, input bit req_at_done);
        int   cyc, st_a, st_b, st_tot, ea;
        bit   fin;
        exp_t e;
        push_groups(n);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        cyc = 1; fin = 1'b0; st_a = 0; st_b = 0; st_tot = 0;
        while (!fin) begin
            if (cyc > 60) begin
                check_val("done_timeout", 64'(obs_done), 64'(1'b1));
                fin = 1'b1;
            end else begin
                check_val("busy_stall", 64'({obs_busy, obs_stall}), 64'(2'b11));
                if (obs_done) begin
                    check_val("done_latency", 64'(cyc), 64'((n + 3) / 4 + 2 + st_tot));
                    check_val("sb_empty", 64'(sb.size()), 64'(0));
                    req = req_at_done;
                    fin = 1'b1;
                end else begin
                    ready = 1'b1;
                    if (obs_we != 4'b0000) begin
                        if (sb.size() == 0) begin
                            check_val("unexpected_group", 64'(obs_we), 64'(4'b0000));
                        end else begin
                            e = sb[0];
                            if (int'(e.grp) == rst_grp) begin
                                #2 reset = 1'b0;
                                #1;
                                check_val("rst_async_we", 64'(obs_we), 64'(4'b0000));
                                check_val("rst_async_busy", 64'({obs_busy, obs_stall}), 64'(2'b00));
                                @(negedge clk);
                                reset = 1'b1;
                                sb.delete();
                                ready = 1'b1;
                                return;
                            end
                            if (int'(e.grp) == sa && st_a < slen) begin
                                ready = 1'b0; st_a++; st_tot++;
                            end else if (int'(e.grp) == sb_g && st_b < slen) begin
                                ready = 1'b0; st_b++; st_tot++;
                            end
                            check_val("rmt_we", 64'(obs_we), 64'(e.mask));
                            check_val("rmt_pkt", 64'(obs_pkts), 64'(e.pkts));
                            ea = (int'(e.grp) + 1) * 4;
                            if (ea >= n) ea = 0;
                            check_val("rd_addr0", 64'(obs_addr0), 64'(ea));
                            if (ready) void'(sb.pop_front());
                        end
                    end
                    req = (cyc == ovr_at);
                end
            end
            @(negedge clk);
            cyc++;
        end
        req = 1'b0;
        ready = 1'b1;
        check_val("idle_after_done", 64'({obs_busy, obs_stall, obs_done, obs_we}), 64'(7'd0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_we", 64'({bus_a.rmtWe_o, bus_b.rmtWe_o}), 64'(8'd0));
        check_val("rst_pkt", 64'(obs_pkts), 64'(0));
        check_val("rst_status", 64'({obs_busy, obs_stall, obs_done, obs_ovr}), 64'(4'd0));
        reset = 1'b1;
        @(negedge clk);

        // Basic restore, then backpressure on groups 2 and 5.
        run_restore(34, -1, -1, 0, -1, -1, 1'b0);
        check_val("ovr_clear", 64'(obs_ovr), 64'(1'b0));
        run_restore(34, 2, 5, 2, -1, -1, 1'b0);
`ifdef RECOVER_STATS_EN
        check_val("stat_count", 64'(bus_a.recoverCount_o), 64'(16'd2));
        check_val("stat_stall", 64'(bus_a.stallCycles_o), 64'(16'd4));
`endif
        // Overrun request mid-walk.
        run_restore(34, -1, -1, 0, 5, -1, 1'b0);
        check_val("ovr_set", 64'(obs_ovr), 64'(1'b1));
        repeat (3) @(negedge clk);
        check_val("ovr_sticky", 64'(obs_ovr), 64'(1'b1));

        // Async reset at group 4, then a clean restart.
        run_restore(34, -1, -1, 0, -1, 4, 1'b0);
        check_val("ovr_after_rst", 64'(obs_ovr), 64'(1'b0));
        run_restore(34, -1, -1, 0, -1, -1, 1'b0);

        // Exact-multiple map, with a request landing on the DONE cycle.
        sel = 1'b1;
        @(negedge clk);
        check_val("b_ovr_clear", 64'(obs_ovr), 64'(1'b0));
        run_restore(32, -1, -1, 0, -1, -1, 1'b1);
        check_val("b_ovr_done_req", 64'(obs_ovr), 64'(1'b1));
        @(negedge clk);
        check_val("b_idle_after", 64'({obs_busy, obs_we}), 64'(5'd0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
